// File: rtl/mdu_defs.sv
// rtl/mdu_defs.sv - mdu opcode encodings, latency defaults and md-class decode
package mdu_defs;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MSUB  = 4'd8
  } mdu_op_e;

  localparam int MDU_MUL_LAT = 5;
  localparam int MDU_DIV_LAT = 10;

  // True for ops that occupy the unit for a multi-cycle latency
  function automatic logic mdu_is_multi(input logic [3:0] op);
    logic r;
    r = (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_MADD) || (op == MDU_MSUB);
`endif
    return r;
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - IDLE/RUN latency counter FSM producing busy and commit strobe
module mdu_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             launch,
  input  logic [CNT_W-1:0] lat,
  output logic             busy,
  output logic             commit
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers; reset aborts any op in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load the latency on launch, count down while running, leave on the last cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_RUN;
          cnt_d   = lat;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // busy comes straight from the state flop; commit fires on the final RUN cycle
  always_comb begin
    busy   = (state_q == S_RUN);
    commit = (state_q == S_RUN) && (cnt_q == CNT_W'(1));
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multiply/divide unit with HI/LO; MDU_MADD_EN adds MADD/MSUB
module mul_div_unit
  import mdu_defs::*;
#(
  parameter int MUL_LAT = MDU_MUL_LAT,
  parameter int DIV_LAT = MDU_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        occupied,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] ph_q, ph_d, pl_q, pl_d;
  logic        dz_q, dz_d;

  logic             accept, launch, commit, is_div;
  logic [CNT_W-1:0] lat;
  logic [63:0]      a_sx, b_sx, prod_s, prod_u;
  logic [31:0]      quot, rem;

  mdu_ctrl #(.CNT_W(CNT_W)) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .launch (launch),
    .lat    (lat),
    .busy   (busy),
    .commit (commit)
  );

  // Decode: starts are only honoured while idle; hazard unit sees occupied a cycle early
  always_comb begin
    accept   = start && !busy;
    launch   = accept && mdu_is_multi(mdu_op);
    occupied = busy || (start && mdu_is_multi(mdu_op));
    is_div   = (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);
    lat      = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
  end

  // Arithmetic: 64-bit products and truncating divide; zero divisor yields don't-care zeros
  always_comb begin
    a_sx   = {{32{A[31]}}, A};
    b_sx   = {{32{B[31]}}, B};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, A} * {32'd0, B};
    quot   = '0;
    rem    = '0;
    if (B != 32'd0) begin
      if (mdu_op == MDU_DIV) begin
        quot = $signed(A) / $signed(B);
        rem  = $signed(A) % $signed(B);
      end else begin
        quot = A / B;
        rem  = A % B;
      end
    end
  end

  // Pending result captured at the start edge; a divide by zero marks the commit as void
  always_comb begin
    ph_d = ph_q;
    pl_d = pl_q;
    dz_d = dz_q;
    if (launch) begin
      dz_d = 1'b0;
      case (mdu_op)
        MDU_MULT:  {ph_d, pl_d} = prod_s;
        MDU_MULTU: {ph_d, pl_d} = prod_u;
        MDU_DIV, MDU_DIVU: begin
          pl_d = quot;
          ph_d = rem;
          dz_d = (B == 32'd0);
        end
`ifdef MDU_MADD_EN
        MDU_MADD:  {ph_d, pl_d} = {hi_q, lo_q} + prod_s;
        MDU_MSUB:  {ph_d, pl_d} = {hi_q, lo_q} - prod_s;
`endif
        default: ;
      endcase
    end
  end

  // HI/LO update: commit of a pending result, or an immediate MTHI/MTLO write
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit && !dz_q) begin
      hi_d = ph_q;
      lo_d = pl_q;
    end else if (accept && (mdu_op == MDU_MTHI)) begin
      hi_d = A;
    end else if (accept && (mdu_op == MDU_MTLO)) begin
      lo_d = A;
    end
  end

  // Datapath registers; reset clears everything so an aborted op never commits
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
      ph_q <= '0;
      pl_q <= '0;
      dz_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      ph_q <= ph_d;
      pl_q <= pl_d;
      dz_q <= dz_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] A, B;
  logic        busy, occupied;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  int n;

  mul_div_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mdu_op   (mdu_op),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .occupied (occupied),
    .HI       (HI),
    .LO       (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; presents the op for one cycle and returns at the next negedge
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic exp_occ, input string tag);
    start  = 1'b1;
    mdu_op = op;
    A      = a;
    B      = b;
    #1;
    chk({tag, "_occupied"}, {31'd0, occupied}, {31'd0, exp_occ});
    @(negedge clk);
    start  = 1'b0;
    mdu_op = 4'd0;
  endtask

  task automatic wait_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    mdu_op = 4'd0;
    A      = '0;
    B      = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_occ", {31'd0, occupied}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    start_op(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b1, "mult");
    wait_busy(n);
    chk("mult_lat", n, 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFE);

    start_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, "multu");
    wait_busy(n);
    chk("multu_lat", n, 32'd5);
    chk("multu_hi", HI, 32'h0000_0001);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    start_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, "div");
    wait_busy(n);
    chk("div_lat", n, 32'd10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    start_op(4'd4, 32'd7, 32'd2, 1'b1, "divu");
    wait_busy(n);
    chk("divu_lat", n, 32'd10);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    start_op(4'd5, 32'h11, 32'd0, 1'b0, "mthi11");
    start_op(4'd6, 32'h22, 32'd0, 1'b0, "mtlo22");
    start_op(4'd4, 32'd7, 32'd0, 1'b1, "divz");
    wait_busy(n);
    chk("divz_lat", n, 32'd10);
    chk("divz_hi", HI, 32'h11);
    chk("divz_lo", LO, 32'h22);

    start_op(4'd5, 32'hDEAD_BEEF, 32'd0, 1'b0, "mthi");
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", HI, 32'hDEAD_BEEF);
    start_op(4'd1, 32'd3, 32'd4, 1'b1, "b2b");
    wait_busy(n);
    chk("b2b_lat", n, 32'd5);
    chk("b2b_hi", HI, 32'd0);
    chk("b2b_lo", LO, 32'd12);

    start_op(4'd0, 32'd9, 32'd9, 1'b0, "none");
    chk("none_busy", {31'd0, busy}, 32'd0);
    chk("none_lo", LO, 32'd12);

    start_op(4'd5, 32'hAA, 32'd0, 1'b0, "mthiaa");
    start_op(4'd6, 32'hBB, 32'd0, 1'b0, "mtlobb");
    start_op(4'd1, 32'd5, 32'd6, 1'b1, "abort");
    repeat (2) @(negedge clk);
    chk("abort_busy3", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_busy_late", {31'd0, busy}, 32'd0);
    chk("abort_hi_late", HI, 32'd0);
    chk("abort_lo_late", LO, 32'd0);

    start_op(4'd5, 32'd0, 32'd0, 1'b0, "mthi0");
    start_op(4'd6, 32'd5, 32'd0, 1'b0, "mtlo5");
`ifdef MDU_MADD_EN
    start_op(4'd7, 32'd3, 32'd4, 1'b1, "madd");
    wait_busy(n);
    chk("madd_lat", n, 32'd5);
    chk("madd_hi", HI, 32'd0);
    chk("madd_lo", LO, 32'd17);
    start_op(4'd8, 32'd1, 32'd20, 1'b1, "msub");
    wait_busy(n);
    chk("msub_lat", n, 32'd5);
    chk("msub_hi", HI, 32'hFFFF_FFFF);
    chk("msub_lo", LO, 32'hFFFF_FFFD);
`else
    start_op(4'd7, 32'd3, 32'd4, 1'b0, "madd_off");
    chk("madd_off_busy", {31'd0, busy}, 32'd0);
    chk("madd_off_hi", HI, 32'd0);
    chk("madd_off_lo", LO, 32'd5);
    start_op(4'd8, 32'd1, 32'd20, 1'b0, "msub_off");
    repeat (6) @(negedge clk);
    chk("msub_off_hi", HI, 32'd0);
    chk("msub_off_lo", LO, 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
